// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART TX core: one-hot FSM state encodings and
// FIFO/parity control levels, used by both the TX FSM and the TX shifter.
package uart_tx_pkg;

    typedef logic [4:0] tx_state_t;

    localparam tx_state_t INTERVAL  = 5'b00001;
    localparam tx_state_t STARTBIT  = 5'b00010;
    localparam tx_state_t DATABITS  = 5'b00100;
    localparam tx_state_t PARITYBIT = 5'b01000;
    localparam tx_state_t STOPBIT   = 5'b10000;

    localparam logic FIFO_EMPTY    = 1'b1;
    localparam logic FIFO_NONEMPTY = 1'b0;

    localparam logic PARITY_ENABLE  = 1'b1;
    localparam logic PARITY_DISABLE = 1'b0;

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter for triplicated registers.
module tmr_voter #(
    parameter int unsigned Width = 1
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] c_i,
    output logic [Width-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (b_i & c_i) | (c_i & a_i);

endmodule

// File: rtl/uart_tx_shifter.sv
// UART TX datapath: fetches one FIFO byte per frame, shifts it out LSB first with
// optional parity, and drives the tx line. Define UART_TX_SHIFTER_TMR_EN for TMR state.
module uart_tx_shifter
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_BaudSig_i,
    input  logic [4:0]            State_i,
    input  logic [3:0]            BitCounter_i,
    input  logic                  p_ParityCalTrigger_i,
    input  logic                  ParityEnable_i,
    input  logic                  ParityOdd_i,
    input  logic [DATA_WIDTH-1:0] FifoData_i,
    input  logic                  p_FiFoEmpty_i,
    output logic                  p_FiFoRdEn_o,
    output logic                  Tx_o,
    output logic                  p_ByteDone_o,
    output logic                  p_Underrun_o
);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    tx_state_t             prev_state_q, prev_state_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  load_q, load_d;
    logic                  underrun_q, underrun_d;
    logic                  byte_done_q, byte_done_d;
    logic                  frame_start;

    always_comb begin
        frame_start  = (State_i == STARTBIT) && (prev_state_q == INTERVAL);
        prev_state_d = State_i;
        rd_en_d      = frame_start && (p_FiFoEmpty_i == FIFO_NONEMPTY);
        underrun_d   = frame_start && (p_FiFoEmpty_i == FIFO_EMPTY);
        // FIFO data is valid the clk after the read pulse, so load one clk later.
        load_d       = rd_en_q;
        byte_done_d  = (State_i == STOPBIT) && p_BaudSig_i;

        shift_d = shift_q;
        if (underrun_d) begin
            shift_d = '0;
        end else if (load_q) begin
            shift_d = FifoData_i;
        end else if ((State_i == DATABITS) && p_BaudSig_i) begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end

        parity_d = parity_q;
        if (p_ParityCalTrigger_i && (State_i == STARTBIT)) begin
            parity_d = (^shift_q) ^ ParityOdd_i;
        end

        tx_d = IDLE_LEVEL;
        case (State_i)
            INTERVAL:  tx_d = IDLE_LEVEL;
            STARTBIT:  tx_d = 1'b0;
            DATABITS:  tx_d = shift_q[0];
            PARITYBIT: tx_d = (ParityEnable_i == PARITY_ENABLE) ? parity_q : IDLE_LEVEL;
            STOPBIT:   tx_d = IDLE_LEVEL;
            default:   tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q     <= 1'b0;
            load_q      <= 1'b0;
            underrun_q  <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            rd_en_q     <= rd_en_d;
            load_q      <= load_d;
            underrun_q  <= underrun_d;
            byte_done_q <= byte_done_d;
        end
    end

`ifdef UART_TX_SHIFTER_TMR_EN
    (* syn_preserve = 1 *) logic [DATA_WIDTH-1:0] shift_a_q, shift_b_q, shift_c_q;
    (* syn_preserve = 1 *) logic                  parity_a_q, parity_b_q, parity_c_q;
    (* syn_preserve = 1 *) tx_state_t             prev_a_q, prev_b_q, prev_c_q;
    (* syn_preserve = 1 *) logic                  tx_a_q, tx_b_q, tx_c_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_a_q  <= '0;
            shift_b_q  <= '0;
            shift_c_q  <= '0;
            parity_a_q <= 1'b0;
            parity_b_q <= 1'b0;
            parity_c_q <= 1'b0;
            prev_a_q   <= INTERVAL;
            prev_b_q   <= INTERVAL;
            prev_c_q   <= INTERVAL;
            tx_a_q     <= IDLE_LEVEL;
            tx_b_q     <= IDLE_LEVEL;
            tx_c_q     <= IDLE_LEVEL;
        end else begin
            shift_a_q  <= shift_d;
            shift_b_q  <= shift_d;
            shift_c_q  <= shift_d;
            parity_a_q <= parity_d;
            parity_b_q <= parity_d;
            parity_c_q <= parity_d;
            prev_a_q   <= prev_state_d;
            prev_b_q   <= prev_state_d;
            prev_c_q   <= prev_state_d;
            tx_a_q     <= tx_d;
            tx_b_q     <= tx_d;
            tx_c_q     <= tx_d;
        end
    end

    tmr_voter #(.Width(DATA_WIDTH)) u_vote_shift (
        .a_i  (shift_a_q),
        .b_i  (shift_b_q),
        .c_i  (shift_c_q),
        .maj_o(shift_q)
    );

    tmr_voter #(.Width(1)) u_vote_parity (
        .a_i  (parity_a_q),
        .b_i  (parity_b_q),
        .c_i  (parity_c_q),
        .maj_o(parity_q)
    );

    tmr_voter #(.Width(5)) u_vote_prev (
        .a_i  (prev_a_q),
        .b_i  (prev_b_q),
        .c_i  (prev_c_q),
        .maj_o(prev_state_q)
    );

    tmr_voter #(.Width(1)) u_vote_tx (
        .a_i  (tx_a_q),
        .b_i  (tx_b_q),
        .c_i  (tx_c_q),
        .maj_o(tx_q)
    );
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q      <= '0;
            parity_q     <= 1'b0;
            prev_state_q <= INTERVAL;
            tx_q         <= IDLE_LEVEL;
        end else begin
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            prev_state_q <= prev_state_d;
            tx_q         <= tx_d;
        end
    end
`endif

    assign Tx_o         = tx_q;
    assign p_FiFoRdEn_o = rd_en_q;
    assign p_Underrun_o = underrun_q;
    assign p_ByteDone_o = byte_done_q;

    a_bitcnt_range: assert property (@(posedge clk) disable iff (!rst)
        (State_i == DATABITS) |-> ({28'd0, BitCounter_i} < DATA_WIDTH));

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Scoreboarded bench for uart_tx_shifter: drives an FSM-like state sequence and a
// FIFO model; a UART-style monitor samples mid-bit and checks each frame.
module tb_uart_tx_shifter;
    import uart_tx_pkg::*;

    localparam int BaudClks = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_BaudSig_i = 1'b0;
    logic [4:0] State_i = INTERVAL;
    logic [3:0] BitCounter_i = '0;
    logic       p_ParityCalTrigger_i = 1'b0;
    logic       ParityEnable_i = 1'b1;
    logic       ParityOdd_i = 1'b0;
    logic [7:0] fifo_rdata = 8'h00;
    logic [7:0] fifo_next = 8'h00;
    logic       p_FiFoEmpty_i = 1'b0;
    logic       p_FiFoRdEn_o;
    logic       Tx_o;
    logic       p_ByteDone_o;
    logic       p_Underrun_o;

    uart_tx_shifter #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .p_BaudSig_i         (p_BaudSig_i),
        .State_i             (State_i),
        .BitCounter_i        (BitCounter_i),
        .p_ParityCalTrigger_i(p_ParityCalTrigger_i),
        .ParityEnable_i      (ParityEnable_i),
        .ParityOdd_i         (ParityOdd_i),
        .FifoData_i          (fifo_rdata),
        .p_FiFoEmpty_i       (p_FiFoEmpty_i),
        .p_FiFoRdEn_o        (p_FiFoRdEn_o),
        .Tx_o                (Tx_o),
        .p_ByteDone_o        (p_ByteDone_o),
        .p_Underrun_o        (p_Underrun_o)
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears the clk after the read pulse.
    always @(posedge clk) if (p_FiFoRdEn_o) fifo_rdata <= fifo_next;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          rd;
        int          un;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic exp_t make_exp(input logic [7:0] d, input bit pen, input bit odd,
                                      input bit empty);
        exp_t       e;
        logic [7:0] dd;
        dd = empty ? 8'h00 : d;
        e.bits = '0;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1+i] = dd[i];
        e.nbits = 9;
        if (pen) begin
            e.bits[9] = (^dd) ^ odd;
            e.nbits = 10;
        end
        e.bits[e.nbits] = 1'b1;
        e.nbits++;
        e.rd = empty ? 0 : 1;
        e.un = empty ? 1 : 0;
        return e;
    endfunction

    // Monitor: UART-style receiver plus pulse counters, compared at each ByteDone.
    exp_t cur;
    bit   mon_busy = 0;
    int   cnt = 0;
    int   bit_idx = 0;
    int   rd_cnt = 0;
    int   un_cnt = 0;
    int   frame_no = 0;
    logic tx_prev = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            mon_busy = 0;
            rd_cnt   = 0;
            un_cnt   = 0;
            tx_prev  = 1'b1;
        end else begin
            if (p_FiFoRdEn_o) rd_cnt++;
            if (p_Underrun_o) un_cnt++;
            if (!mon_busy) begin
                if (tx_prev === 1'b1 && Tx_o === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        cur      = exp_q.pop_front();
                        mon_busy = 1;
                        cnt      = 0;
                        bit_idx  = 0;
                    end
                end
            end else begin
                cnt++;
                if (bit_idx < cur.nbits && cnt == BaudClks / 2 + BaudClks * bit_idx) begin
                    check($sformatf("frame%0d_bit%0d", frame_no, bit_idx), {31'd0, Tx_o},
                          {31'd0, cur.bits[bit_idx]});
                    bit_idx++;
                end
            end
            if (p_ByteDone_o) begin
                check($sformatf("frame%0d_done_complete", frame_no),
                      {31'd0, mon_busy && bit_idx == cur.nbits}, 32'd1);
                check($sformatf("frame%0d_rden_count", frame_no), rd_cnt, cur.rd);
                check($sformatf("frame%0d_underrun_count", frame_no), un_cnt, cur.un);
                mon_busy = 0;
                rd_cnt   = 0;
                un_cnt   = 0;
                frame_no++;
            end
            tx_prev = Tx_o;
        end
    end

    task automatic cycle(input logic [4:0] st, input logic [3:0] bc, input bit baud,
                         input bit trig);
        State_i              = st;
        BitCounter_i         = bc;
        p_BaudSig_i          = baud;
        p_ParityCalTrigger_i = trig;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(INTERVAL, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [7:0] d, input bit pen, input bit odd, input bit empty,
                         input int gap, input int abort_bit, input bit upset);
        exp_q.push_back(make_exp(d, pen, odd, empty));
        fifo_next      = d;
        p_FiFoEmpty_i  = empty;
        ParityEnable_i = pen;
        ParityOdd_i    = odd;
        idle(gap);
        for (int i = 0; i < BaudClks; i++)
            cycle(STARTBIT, 4'd0, i == BaudClks - 1, i == BaudClks / 2);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < BaudClks; i++) begin
                if (k == abort_bit && i == BaudClks / 2) begin
                    rst = 1'b0;
                    #1;
                    check("abort_tx_idle", {31'd0, Tx_o}, 32'd1);
                    check("abort_rden", {31'd0, p_FiFoRdEn_o}, 32'd0);
                    check("abort_bytedone", {31'd0, p_ByteDone_o}, 32'd0);
                    check("abort_underrun", {31'd0, p_Underrun_o}, 32'd0);
                    State_i              = INTERVAL;
                    p_BaudSig_i          = 1'b0;
                    p_ParityCalTrigger_i = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    rst = 1'b1;
                    return;
                end
`ifdef UART_TX_SHIFTER_TMR_EN
                if (upset && k == 2 && i == 4) force dut.shift_a_q = 8'hFF;
                if (upset && k == 4 && i == 4) release dut.shift_a_q;
`endif
                cycle(DATABITS, 4'(k), i == BaudClks - 1, 1'b0);
            end
        end
        if (pen) for (int i = 0; i < BaudClks; i++) cycle(PARITYBIT, 4'd0, i == BaudClks - 1, 1'b0);
        for (int i = 0; i < BaudClks; i++) cycle(STOPBIT, 4'd0, i == BaudClks - 1, 1'b0);
        State_i = INTERVAL;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, Tx_o}, 32'd1);
        check("reset_rden", {31'd0, p_FiFoRdEn_o}, 32'd0);
        check("reset_bytedone", {31'd0, p_ByteDone_o}, 32'd0);
        check("reset_underrun", {31'd0, p_Underrun_o}, 32'd0);
        rst = 1'b1;
        idle(4);
        check("idle_tx", {31'd0, Tx_o}, 32'd1);

        frame(8'hA5, 1'b1, 1'b0, 1'b0, 4, -1, 1'b0);  // even parity -> 0
        frame(8'hA5, 1'b1, 1'b1, 1'b0, 4, -1, 1'b0);  // odd parity -> 1
        frame(8'hA5, 1'b0, 1'b0, 1'b0, 4, -1, 1'b0);  // no parity, 10-bit frame
        frame(8'h77, 1'b1, 1'b0, 1'b1, 4, -1, 1'b0);  // underrun: zeros sent
        frame(8'h5A, 1'b1, 1'b0, 1'b0, 4, 3, 1'b0);   // reset during data bit 3
        idle(4);
        check("post_reset_tx", {31'd0, Tx_o}, 32'd1);
        frame(8'h3C, 1'b1, 1'b0, 1'b0, 4, -1, 1'b0);
        frame(8'h00, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);  // back-to-back pair
        frame(8'hFF, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
`ifdef UART_TX_SHIFTER_TMR_EN
        frame(8'hA5, 1'b1, 1'b0, 1'b0, 4, -1, 1'b1);  // single-copy upset masked
`endif
        idle(20);
        check("queue_drained", exp_q.size(), 32'd0);
        check("monitor_idle", {31'd0, mon_busy}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_shifter.md
Name: uart_tx_shifter

Overview:
- Datapath stage directly downstream of the TX core state machine.
- Consumes the one-hot state, bit counter, baud pulse and parity trigger.
- Fetches one byte from the TX FIFO per frame, shifts it out LSB first, inserts parity, and drives the serial TX line.
- Sole driver of the physical tx pin.

Parameters:
DATA_WIDTH, 8, data bits per frame; must equal the FSM bit count (FSM counts 0..DATA_WIDTH-1).
IDLE_LEVEL, 1'b1, line level in INTERVAL, STOPBIT, reset and illegal states.

Ports:
clk  input  1  system clock, >=40 MHz
rst  input  1  asynchronous active-low reset; release synchronous to clk
p_BaudSig_i  input  1  one-clk baud pulse, same pulse that drives the FSM
State_i  input  5  one-hot FSM state: INTERVAL=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000
BitCounter_i  input  4  FSM data-bit counter
p_ParityCalTrigger_i  input  1  FSM parity trigger pulse
ParityEnable_i  input  1  1 = parity bit present in frame
ParityOdd_i  input  1  1 = odd parity, 0 = even
FifoData_i  input  DATA_WIDTH  FIFO read data, valid one clk after read enable
p_FiFoEmpty_i  input  1  FIFO empty flag, 1 = empty
p_FiFoRdEn_o  output  1  one-clk FIFO read pulse
Tx_o  output  1  serial line
p_ByteDone_o  output  1  one-clk pulse at end of stop bit
p_Underrun_o  output  1  one-clk pulse when a frame started with the FIFO empty

Behaviour:
- Reset, asynchronous:
  - Tx_o = IDLE_LEVEL.
  - p_FiFoRdEn_o, p_ByteDone_o, p_Underrun_o = 0.
  - Shift register = 0, parity register = 0, previous-state register = INTERVAL.
- Entry detection:
  - prev_state_r registers State_i every clk.
  - Frame start = (State_i == STARTBIT) and (prev_state_r == INTERVAL).
- FIFO read:
  - On frame start, p_FiFoRdEn_o = 1 for exactly one clk if p_FiFoEmpty_i = 0.
  - If p_FiFoEmpty_i = 1 on frame start: no read, p_Underrun_o pulses one clk, and the shift register loads all zeros in place of FIFO data.
- Load: the clk after the read pulse, shift_r <= FifoData_i. Load completes within the start bit (baud period is much greater than 2 clk).
- Parity:
  - On p_ParityCalTrigger_i = 1 while State_i == STARTBIT, parity_r <= (^shift_r) ^ ParityOdd_i.
  - Trigger pulses in any other state are ignored.
- Shift: in DATABITS, on p_BaudSig_i = 1, shift_r shifts right by one, zero-filling the MSB.
- Tx_o is registered, one clk latency after State_i / shift_r:
  - INTERVAL: IDLE_LEVEL
  - STARTBIT: 0
  - DATABITS: shift_r[0]
  - PARITYBIT: parity_r if ParityEnable_i = 1, else IDLE_LEVEL
  - STOPBIT: IDLE_LEVEL
  - Any non-one-hot State_i: IDLE_LEVEL
- p_ByteDone_o: pulses one clk when State_i == STOPBIT and p_BaudSig_i = 1.
- BitCounter_i is used only for the assertion check: in DATABITS, BitCounter_i must be < DATA_WIDTH.
- Simultaneous events:
  - Frame start and baud pulse in the same clk: the read is still issued.
  - Reset mid-frame: Tx_o returns to IDLE_LEVEL immediately; the partial byte is discarded; no ByteDone pulse.
- Back-to-back frames (STOPBIT -> INTERVAL -> STARTBIT): a new read is issued per frame; no data carries over from the previous frame.

Optional Feature:
- Macro: UART_TX_SHIFTER_TMR_EN.
- Defined:
  - shift_r, parity_r, prev_state_r and the Tx_o register are each triplicated (A/B/C copies), all marked syn_preserve.
  - All logic reads the bitwise majority of the three copies, matching the FSM's TMR scheme.
  - A single-copy upset is masked at the output.
- Undefined: single copies only; function and timing are identical.

Decomposition:
- Package uart_tx_pkg holds:
  - the one-hot state constants (INTERVAL..STOPBIT);
  - FIFO EMPTY/NONEMPTY levels;
  - parity ENABLE/DISABLE levels.
  The FSM shares the same package.
- One sub-module, tmr_voter, parameterised on width, returns (a&b)|(b&c)|(c&a). It is instantiated only under UART_TX_SHIFTER_TMR_EN.

Test Plan:
1. Byte 0xA5, parity even, FIFO non-empty, 16-clk baud period -> Tx_o sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop); one RdEn pulse; one ByteDone pulse.
2. Byte 0xA5, ParityOdd_i = 1 -> parity bit = 1. Same byte with ParityEnable_i = 0 -> FSM skips PARITYBIT; 10-bit frame ending 1.
3. Frame start with p_FiFoEmpty_i = 1 -> no RdEn, Underrun pulses once, data bits all 0, stop bit 1.
4. Assert rst low during DATABITS bit 3 -> Tx_o = 1 within the same clk; all pulses 0; next frame (0x3C) transmits cleanly.
5. Back-to-back bytes 0x00 then 0xFF -> exactly two RdEn pulses; second frame's data bits all 1, even parity bit 0.
6. With the macro defined, force one copy of shift_r to the wrong value mid-frame -> Tx_o sequence unchanged from the golden run.
